// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: word-addressed fetch storage behind a byte-address
// valid/ready request/response pair, fixed access latency, plus a program-load write port.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_instr_o,
  output logic [1:0]  resp_error_o,
  input  logic        prog_we_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_data_i,
  output logic [31:0] fetch_count_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  // Addresses below BASE_ADDR are rejected before the subtraction is trusted,
  // so a wrapped offset can never alias a valid word.
  function automatic logic [1:0] addr_err(input logic [31:0] a);
    if (a[1:0] != 2'b00)                               return ERR_ALIGN;
    else if (a < BASE_ADDR)                            return ERR_RANGE;
    else if (((a - BASE_ADDR) >> (IW + 2)) != 32'd0)   return ERR_RANGE;
    else                                               return ERR_OK;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   count_q, count_d;
  logic          load;
  logic [31:0]   rd_addr;

  assign req_ready_o   = (state_q == S_IDLE) && !reset_i;
  assign resp_valid_o  = (state_q == S_RESP);
  assign resp_instr_o  = instr_q;
  assign resp_error_o  = err_q;
  assign fetch_count_o = count_q;

  // With LATENCY==1 the read happens on the accepting edge, before addr_q holds it.
  assign rd_addr = (state_q == S_IDLE) ? req_addr_i : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    count_d = count_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d = req_addr_i;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            load    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
          count_d = count_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      err_d   = addr_err(rd_addr);
      instr_d = (err_d == ERR_OK) ? mem[word_idx(rd_addr)] : 32'd0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= ERR_OK;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Contents survive reset; a same-edge read sees the pre-write word.
  always_ff @(posedge clock_i) begin
    if (prog_we_i && (addr_err(prog_addr_i) == ERR_OK))
      mem[word_idx(prog_addr_i)] <= prog_data_i;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: u0 default, u1 BASE_ADDR=0x100, u2 LATENCY=1; shared inputs except req_valid.
module tb_instr_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        rv;
  logic [31:0]       req_addr;
  logic              resp_ready;
  logic              prog_we;
  logic [31:0]       prog_addr, prog_data;
  logic [2:0]        rdy, vld;
  logic [2:0][31:0]  instr;
  logic [2:0][1:0]   err;
  logic [2:0][31:0]  cnt;

  int nvec = 0;
  int nerr = 0;

  instr_mem_responder u0 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(rv[0]), .req_addr_i(req_addr),
    .req_ready_o(rdy[0]), .resp_valid_o(vld[0]), .resp_ready_i(resp_ready),
    .resp_instr_o(instr[0]), .resp_error_o(err[0]), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_data_i(prog_data), .fetch_count_o(cnt[0]));

  instr_mem_responder #(.BASE_ADDR(32'h0000_0100)) u1 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(rv[1]), .req_addr_i(req_addr),
    .req_ready_o(rdy[1]), .resp_valid_o(vld[1]), .resp_ready_i(resp_ready),
    .resp_instr_o(instr[1]), .resp_error_o(err[1]), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_data_i(prog_data), .fetch_count_o(cnt[1]));

  instr_mem_responder #(.LATENCY(1)) u2 (
    .clock_i(clk), .reset_i(rst), .req_valid_i(rv[2]), .req_addr_i(req_addr),
    .req_ready_o(rdy[2]), .resp_valid_o(vld[2]), .resp_ready_i(resp_ready),
    .resp_instr_o(instr[2]), .resp_error_o(err[2]), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_data_i(prog_data), .fetch_count_o(cnt[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  // Presents a request on DUT k; edges counts clock edges from the accepting one to resp_valid.
  task automatic do_fetch(input int k, input logic [31:0] a, output int edges);
    rv[k] = 1'b1; req_addr = a;
    step();
    edges = 1;
    rv[k] = 1'b0; req_addr = 32'hFFFF_FFF0;
    while (!vld[k] && edges < 20) begin
      step();
      edges++;
    end
    if (!vld[k]) begin
      nvec++; nerr++;
      $display("FAIL fetch_timeout dut=%0d addr=%h: no resp_valid within 20 edges", k, a);
    end
  endtask

  task automatic complete();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = '0; req_addr = '0; resp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step(); step();
    nvec++; if (rdy !== 3'b000) begin nerr++; $display("FAIL rdy_in_reset got=%b want=000", rdy); end
    rst = 1'b0;
    #1;
    nvec++; if (rdy !== 3'b111) begin nerr++; $display("FAIL rdy_after_reset got=%b want=111", rdy); end
    nvec++; if (vld !== 3'b000) begin nerr++; $display("FAIL vld_after_reset got=%b want=000", vld); end
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (cnt[k] !== 32'd0 || instr[k] !== 32'd0 || err[k] !== 2'd0) begin
        nerr++;
        $display("FAIL reset_regs dut=%0d cnt=%h instr=%h err=%0d want all 0", k, cnt[k], instr[k], err[k]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      nvec++; if (vld !== 3'b000) begin nerr++; $display("FAIL idle_vld cyc=%0d got=%b want=000", i, vld); end
    end
  endtask

  task automatic test_load_fetch();
    int e;
    prog_write(32'h0000_0000, 32'h2008_0005);
    prog_write(32'h0000_0004, 32'h0109_5020);
    prog_write(32'h0000_03FC, 32'hCAFE_F00D);
    prog_write(32'h0000_0100, 32'h1111_2222);
    do_fetch(0, 32'h4, e);
    nvec++; if (e !== 2) begin nerr++; $display("FAIL latency got=%0d want=2", e); end
    nvec++; if (instr[0] !== 32'h0109_5020) begin nerr++; $display("FAIL fetch_instr got=%h want=01095020", instr[0]); end
    nvec++; if (err[0] !== 2'd0) begin nerr++; $display("FAIL fetch_err got=%0d want=0", err[0]); end
    nvec++; if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL rdy_in_resp got=%b want=0", rdy[0]); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      rv[0] = 1'b1; req_addr = 32'h0000_0000 + 32'(i * 4);
      step();
      nvec++;
      if (vld[0] !== 1'b1 || instr[0] !== 32'h0109_5020 || err[0] !== 2'd0 || rdy[0] !== 1'b0) begin
        nerr++;
        $display("FAIL stall cyc=%0d vld=%b instr=%h err=%0d rdy=%b want 1/01095020/0/0",
                 i, vld[0], instr[0], err[0], rdy[0]);
      end
    end
    rv[0] = 1'b0;
    complete();
    nvec++; if (rdy[0] !== 1'b1 || vld[0] !== 1'b0) begin nerr++; $display("FAIL post_hs rdy=%b vld=%b want 1/0", rdy[0], vld[0]); end
    nvec++; if (cnt[0] !== 32'd1) begin nerr++; $display("FAIL count_after_hs got=%0d want=1", cnt[0]); end
    nvec++; if (cnt[1] !== 32'd0) begin nerr++; $display("FAIL count_other_dut got=%0d want=0", cnt[1]); end
  endtask

  task automatic test_errors();
    logic [31:0] a0 [5] = '{32'h6, 32'h400, 32'h401, 32'h3FC, 32'h0};
    logic [1:0]  e0 [5] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0};
    logic [31:0] d0 [5] = '{32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h2008_0005};
    logic [31:0] a1 [4] = '{32'h0FC, 32'h100, 32'h0, 32'h500};
    logic [1:0]  e1 [4] = '{2'd2, 2'd0, 2'd2, 2'd2};
    logic [31:0] d1 [4] = '{32'h0, 32'h1111_2222, 32'h0, 32'h0};
    int e;
    for (int i = 0; i < 5; i++) begin
      do_fetch(0, a0[i], e);
      nvec++;
      if (err[0] !== e0[i] || instr[0] !== d0[i]) begin
        nerr++;
        $display("FAIL err_u0 addr=%h err=%0d instr=%h want %0d/%h", a0[i], err[0], instr[0], e0[i], d0[i]);
      end
      complete();
    end
    nvec++; if (cnt[0] !== 32'd6) begin nerr++; $display("FAIL count_u0 got=%0d want=6", cnt[0]); end
    for (int i = 0; i < 4; i++) begin
      do_fetch(1, a1[i], e);
      nvec++;
      if (err[1] !== e1[i] || instr[1] !== d1[i]) begin
        nerr++;
        $display("FAIL err_u1 addr=%h err=%0d instr=%h want %0d/%h", a1[i], err[1], instr[1], e1[i], d1[i]);
      end
      complete();
    end
    nvec++; if (cnt[1] !== 32'd4) begin nerr++; $display("FAIL count_u1 got=%0d want=4", cnt[1]); end
  endtask

  task automatic test_collision();
    int e;
    prog_write(32'h0000_0002, 32'hBAD0_BAD0);
    rv[0] = 1'b1; req_addr = 32'h0;
    step();
    rv[0] = 1'b0;
    nvec++; if (vld[0] !== 1'b0) begin nerr++; $display("FAIL wait_vld got=%b want=0", vld[0]); end
    prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'hDEAD_BEEF;
    step();
    prog_we = 1'b0;
    nvec++;
    if (vld[0] !== 1'b1 || instr[0] !== 32'h2008_0005 || err[0] !== 2'd0) begin
      nerr++;
      $display("FAIL collide_old vld=%b instr=%h err=%0d want 1/20080005/0", vld[0], instr[0], err[0]);
    end
    complete();
    do_fetch(0, 32'h0, e);
    nvec++; if (instr[0] !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL collide_new got=%h want=deadbeef", instr[0]); end
    complete();
    nvec++; if (cnt[0] !== 32'd8) begin nerr++; $display("FAIL count_after_collide got=%0d want=8", cnt[0]); end
  endtask

  task automatic test_reset_mid();
    rv[0] = 1'b1; req_addr = 32'h4;
    step();
    rv[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    nvec++; if (rdy !== 3'b000 || vld !== 3'b000) begin nerr++; $display("FAIL async_reset rdy=%b vld=%b want 000/000", rdy, vld); end
    step(); step();
    rst = 1'b0;
    #1;
    nvec++;
    if (rdy[0] !== 1'b1 || cnt[0] !== 32'd0 || instr[0] !== 32'd0) begin
      nerr++;
      $display("FAIL after_abort rdy=%b cnt=%0d instr=%h want 1/0/0", rdy[0], cnt[0], instr[0]);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++; if (vld[0] !== 1'b0) begin nerr++; $display("FAIL aborted_resp cyc=%0d vld=%b want=0", i, vld[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] dd [4] = '{32'hDEAD_BEEF, 32'h0109_5020, 32'hDEAD_BEEF, 32'h0109_5020};
    int e;
    resp_ready = 1'b1; rv[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = ad[i];
      step();
      nvec++;
      if (vld[2] !== 1'b1 || instr[2] !== dd[i] || rdy[2] !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_resp i=%0d vld=%b instr=%h rdy=%b want 1/%h/0", i, vld[2], instr[2], rdy[2], dd[i]);
      end
      step();
      nvec++;
      if (vld[2] !== 1'b0 || rdy[2] !== 1'b1 || cnt[2] !== 32'(i + 1)) begin
        nerr++;
        $display("FAIL b2b_hs i=%0d vld=%b rdy=%b cnt=%0d want 0/1/%0d", i, vld[2], rdy[2], cnt[2], i + 1);
      end
    end
    rv[2] = 1'b0; resp_ready = 1'b0;
    do_fetch(2, 32'h4, e);
    nvec++; if (e !== 1) begin nerr++; $display("FAIL lat1_latency got=%0d want=1", e); end
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    nvec++;
    if (vld[2] !== 1'b0 || cnt[2] !== 32'd0 || rdy[2] !== 1'b1) begin
      nerr++;
      $display("FAIL lat1_abort vld=%b cnt=%0d rdy=%b want 0/0/1", vld[2], cnt[2], rdy[2]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (vld[2] !== 1'b0) begin nerr++; $display("FAIL lat1_aborted_resp cyc=%0d vld=%b want=0", i, vld[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
